// File: rtl/tt_pwm_multi.sv
// rtl/tt_pwm_multi.sv - TinyTapeout user top with N-channel double-buffered PWM
module tt_pwm_multi #(
    parameter int NUM_CH   = 4,
    parameter int PWM_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [PWM_BITS-1:0] CNT_MAX       = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE       = PWM_BITS'(1);
    localparam logic [2:0]          ADDR_PRESCALE = 3'd7;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    logic                stb_s1_q, stb_s2_q, stb_s3_q;
    logic                mode_s1_q, mode_s2_q;
    logic [7:0]          presc_q, presc_d;
    logic [7:0]          prescale_q, prescale_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    dir_e                dir_q, dir_d;
    logic                mode_q, mode_d;
    logic [PWM_BITS-1:0] shadow_q [NUM_CH];
    logic [PWM_BITS-1:0] shadow_d [NUM_CH];
    logic [PWM_BITS-1:0] active_q [NUM_CH];
    logic [PWM_BITS-1:0] active_d [NUM_CH];
    logic [7:0]          uo_q, uo_d;
    logic                wr, tick, boundary;
    logic [2:0]          wr_addr;
    logic                unused_ok;

    assign wr_addr   = ui_in[6:4];
    assign wr        = ena && stb_s2_q && !stb_s3_q;
    assign unused_ok = &{1'b0, ui_in[2:0]};

    always_comb begin
        presc_d    = presc_q;
        prescale_d = prescale_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        tick       = 1'b0;
        boundary   = 1'b0;
        uo_d       = '0;

        if (!ena) begin
            presc_d = '0;
            cnt_d   = '0;
            dir_d   = DIR_UP;
        end else begin
            // >= so that shrinking the prescale mid-count still ticks promptly
            if (presc_q >= prescale_q) begin
                tick    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + 8'd1;
            end

            if (tick) begin
                if (!mode_q) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (dir_q == DIR_UP) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = cnt_q - CNT_ONE;
                        dir_d = DIR_DOWN;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) dir_d = DIR_UP;
                end

                // Counter is at 0 here in both modes, so a mode switch restarts cleanly
                if (cnt_d == '0) begin
                    boundary = 1'b1;
                    active_d = shadow_q;
                    mode_d   = mode_s2_q;
                    dir_d    = DIR_UP;
                end
            end

            if (wr) begin
                if (wr_addr == ADDR_PRESCALE) prescale_d = uio_in;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (wr_addr == 3'(i)) shadow_d[i] = uio_in[PWM_BITS-1:0];
                end
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            uo_d[i] = ena && (cnt_d < active_d[i]);
        end
        uo_d[7] = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_s1_q   <= 1'b0;
            stb_s2_q   <= 1'b0;
            stb_s3_q   <= 1'b0;
            mode_s1_q  <= 1'b0;
            mode_s2_q  <= 1'b0;
            presc_q    <= '0;
            prescale_q <= '0;
            cnt_q      <= '0;
            dir_q      <= DIR_UP;
            mode_q     <= 1'b0;
            uo_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            stb_s1_q   <= ui_in[7];
            stb_s2_q   <= stb_s1_q;
            stb_s3_q   <= stb_s2_q;
            mode_s1_q  <= ui_in[3];
            mode_s2_q  <= mode_s1_q;
            presc_q    <= presc_d;
            prescale_q <= prescale_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            uo_q       <= uo_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_pwm_multi.sv
// tb/tb_tt_pwm_multi.sv - randomized self-checking bench for tt_pwm_multi
module tb_tt_pwm_multi;

    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic       stb, mode_bit;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    int n_checks = 0;
    int n_fail   = 0;
    int to_cnt   = 0;
    int m_per, m_pad;
    int m_hi [NCH];
    int m_first0;
    int cnt, hi, bad;
    int duty [NCH];
    int psc, md;

    assign ui_in  = {stb, addr, mode_bit, 3'b000};
    assign uio_in = wdata;

    always #5 clk = ~clk;

    tt_pwm_multi #(.NUM_CH(NCH), .PWM_BITS(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: one period visits every counter value once per tick (edge 0..255,
    // center 0..255..1), each tick lasting prescale+1 clocks.
    function automatic int exp_period(input int m, input int p);
        return (m != 0 ? 510 : 256) * (p + 1);
    endfunction

    function automatic int exp_high(input int m, input int d, input int p);
        int vals;
        if (m == 0)      vals = d;
        else if (d == 0) vals = 0;
        else             vals = 2 * d - 1;
        return vals * (p + 1);
    endfunction

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        @(negedge clk);
        stb = 1'b1;
        repeat (5) @(negedge clk);
        stb = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_sync();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uo_out[7] && n < 5000);
        if (!uo_out[7]) to_cnt++;
    endtask

    // Starts on a sample showing the sync pulse, ends on the next one.
    task automatic measure();
        m_per    = 1;
        m_pad    = 0;
        m_first0 = int'(uo_out[0]);
        for (int i = 0; i < NCH; i++) m_hi[i] = int'(uo_out[i]);
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (uo_out[6:NCH] != '0) m_pad++;
            if (uo_out[7]) return;
            m_per++;
            for (int i = 0; i < NCH; i++) m_hi[i] += int'(uo_out[i]);
        end
        to_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; stb = 1'b0; mode_bit = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_uo", uo_out, 0);
        check_eq("rst_uio_out", uio_out, 0);
        check_eq("rst_uio_oe", uio_oe, 0);
        rst_n = 1'b1;
        wait_sync();
        measure();
        check_eq("idle_period", m_per, 256);
        check_eq("idle_ch0", m_hi[0], 0);
        check_eq("idle_ch3", m_hi[3], 0);

        wr_reg(3'd0, 8'h40);
        wr_reg(3'd1, 8'hFF);
        wait_sync();
        measure();
        check_eq("edge_period", m_per, 256);
        check_eq("edge_ch0", m_hi[0], 64);
        check_eq("edge_ch1", m_hi[1], 255);
        check_eq("edge_ch2", m_hi[2], 0);
        check_eq("edge_ch3", m_hi[3], 0);
        check_eq("edge_pad", m_pad, 0);

        wait_sync();
        fork
            measure();
            wr_reg(3'd0, 8'h80);
        join
        check_eq("dbuf_old", m_hi[0], 64);
        measure();
        check_eq("dbuf_new", m_hi[0], 128);

        wr_reg(3'd7, 8'h03);
        wr_reg(3'd0, 8'h10);
        wait_sync();
        measure();
        check_eq("psc_period", m_per, 1024);
        check_eq("psc_ch0", m_hi[0], 64);

        mode_bit = 1'b1;
        wr_reg(3'd7, 8'h00);
        wr_reg(3'd0, 8'h40);
        wait_sync();
        measure();
        check_eq("ctr_period", m_per, 510);
        check_eq("ctr_ch0", m_hi[0], 127);
        check_eq("ctr_ch1", m_hi[1], 509);
        check_eq("ctr_at_zero", m_first0, 1);

        for (int it = 0; it < 4; it++) begin
            md       = int'($urandom_range(0, 1));
            psc      = int'($urandom_range(0, 2));
            mode_bit = md[0];
            for (int i = 0; i < NCH; i++) begin
                duty[i] = int'($urandom_range(0, 255));
                wr_reg(3'(i), 8'(duty[i]));
            end
            wr_reg(3'd7, 8'(psc));
            wait_sync();
            measure();
            check_eq("rnd_period", m_per, exp_period(md, psc));
            for (int i = 0; i < NCH; i++)
                check_eq($sformatf("rnd_ch%0d", i), m_hi[i], exp_high(md, duty[i], psc));
        end

        mode_bit = 1'b0;
        wr_reg(3'd7, 8'h00);
        wr_reg(3'd0, 8'h40);
        wait_sync();
        wait_sync();
        repeat (100) @(negedge clk);
        ena = 1'b0;
        bad = 0;
        fork
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (uo_out != 8'h00) bad++;
            end
            wr_reg(3'd0, 8'hC0);
        join
        check_eq("ena_low_out", bad, 0);
        ena = 1'b1;
        cnt = 0;
        hi  = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (!uo_out[7]) hi += int'(uo_out[0]);
        end while (!uo_out[7] && cnt < 1000);
        check_eq("ena_first_sync", cnt, 256);
        check_eq("ena_first_ch0", hi, 63);
        measure();
        check_eq("ena_retained", m_hi[0], 64);

        repeat (10) @(negedge clk);
        check_eq("pre_rst_ch0", int'(uo_out[0]), 1);
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst_uo", uo_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sync();
        measure();
        check_eq("post_rst_period", m_per, 256);
        check_eq("post_rst_ch0", m_hi[0], 0);
        check_eq("post_rst_ch1", m_hi[1], 0);

        check_eq("timeouts", to_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_pwm_multi.md
Name: tt_pwm_multi

Overview:
Parametrised successor to the single-project TinyTapeout top. It keeps the standard user-project pin interface and adds an N-channel PWM generator. Duty and prescale registers are written through a byte-wide strobed bus on ui_in/uio_in. Each channel uses double-buffered duty registers, selectable edge- or center-aligned counting, and a period-sync output. It is the user-project top instantiated by the chip-level testbench.

Parameters:
NUM_CH, 4, number of PWM channels (1..7), driven on uo_out[NUM_CH-1:0]
PWM_BITS, 8, counter/duty width (4..8)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design-selected enable
ui_in  input  8  [7]=write strobe, [6:4]=register address, [3]=mode (0 edge, 1 center), [2:0] unused
uio_in  input  8  write data; [PWM_BITS-1:0] used for duty, [7:0] for prescale
uo_out  output  8  [NUM_CH-1:0] PWM outputs; [7] period-sync pulse; other bits 0
uio_out  output  8  constant 0
uio_oe  output  8  constant 0 (all bidirectionals are inputs)

Behaviour:
- Reset (async assert, sync release): all shadow/active duty=0, prescale=0, counter=0, direction=up, mode=edge, uo_out=0, synchronisers=0.
- ui_in[7] and ui_in[3] pass through 2-FF synchronisers. Write = rising edge of synchronised strobe, detected 2-3 clk after the pin edge. The write samples ui_in[6:4] and uio_in directly on the detect cycle. The host holds addr/data stable from ≥1 clk before the strobe rises until ≥4 clk after.
- Addresses 0..NUM_CH-1 write shadow duty[addr]=uio_in[PWM_BITS-1:0]. Address 7 writes prescale=uio_in[7:0]. Other addresses are ignored.
- Prescale written at address 7 takes effect immediately. Shadow duties and the mode take effect only at the period boundary.
- Prescaler: a tick fires every prescale+1 clk. The counter advances only on a tick.
- Edge mode: counter 0→MAX (MAX=2^PWM_BITS-1), wraps to 0. Period = (MAX+1) ticks.
- Center mode: counter 0→MAX→0 (up, then down, no repeat at the turning points). Period = 2*MAX ticks.
- Period boundary = the tick on which the counter becomes 0.
  - On that tick, active duty[i] ← shadow duty[i] for all channels, and mode ← synchronised ui_in[3].
  - On a mode change, the counter restarts at 0 counting up.
- uo_out[i] is registered and equals (counter < active duty[i]), evaluated on the post-update counter and duty.
  - duty=0 gives a constant low output.
  - duty=MAX gives high for all but one count value.
- uo_out[7]: high for exactly one clk on the cycle after each period-boundary tick.
- A write landing on the boundary cycle updates the shadow only. The new value goes active at the next boundary, so writes are never torn.
- ena=0:
  - prescaler and counter are held at 0;
  - uo_out is forced to 0;
  - writes are ignored;
  - registers retain their values.
  - When ena rises, counting resumes from counter 0 with no sync pulse until the first boundary.
- rst_n asserted mid-period clears everything asynchronously, and outputs go low in the same cycle.

Test Plan:
- Reset values: assert rst_n=0 with ena=1, clk running → uo_out=0x00, uio_out=0x00, uio_oe=0x00. Release, no writes → uo_out stays 0x00, and uo_out[7] pulses every 256 clk (prescale 0, edge mode).
- Edge duty: write addr0=0x40, addr1=0xFF, prescale 0 → after the next boundary, ch0 high 64 of 256 clk, ch1 high 255 of 256 clk, ch2/ch3 constant low.
- Double buffer: during a period with ch0 active duty=0x40, write ch0=0x80 mid-period → ch0 keeps 64-clk high width for the rest of that period and switches to 128 from the next boundary.
- Prescale: write addr7=0x03, ch0=0x10 → sync pulse every 1024 clk, ch0 high 64 clk per period.
- Center mode: set ui_in[3]=1, ch0=0x40, prescale 0 → after the boundary, period=510 clk and ch0 high 127 clk, centred on the counter-0 point.
- ena/reset mid-operation: drop ena for 50 clk mid-period → uo_out=0, then the period restarts at 0 with the duty retained. Assert rst_n mid-period → all outputs go 0 immediately and duty reads back as 0 (no output until rewritten).
